alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 16 +
 rtl/alu_arbiter_rr.sv | 19 +
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way winner selection: a lone valid requester wins, ties go to the one not granted last.
module alu_arbiter_rr (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_idx_c,
    output logic       grant_vld_c
);

    always_comb begin
        grant_vld_c = |valid_i;
        grant_idx_c = 1'b0;
        if (valid_i == 2'b11) begin
            grant_idx_c = ~last_grant_i;
        end else if (valid_i == 2'b10) begin
            grant_idx_c = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU: IDLE -> EXEC -> RESP -> IDLE.
// Define ALU_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_op5,
    input  logic [3:0]           req_aluop,
    input  logic [5:0]           req_funct3,
    input  logic [1:0]           req_funct7_5,
    input  logic [2*XLEN-1:0]    req_a,
    input  logic [2*XLEN-1:0]    req_b,
    output logic                 alu_op5,
    output logic [1:0]           alu_aluop,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7_5,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_zero
);

    state_e            state_q, state_d;
    logic              op5_q, op5_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              funct7_5_q, funct7_5_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              last_grant;
    logic              grant_idx;
    logic              grant_vld;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    // Pinning "last grant" to requester 1 makes requester 0 win every tie.
    assign last_grant = 1'b1;
`else
    logic last_q, last_d;
    assign last_grant = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    alu_arbiter_rr u_rr (
        .valid_i      (req_valid),
        .last_grant_i (last_grant),
        .grant_idx_c  (grant_idx),
        .grant_vld_c  (grant_vld)
    );

    always_comb begin
        state_d      = state_q;
        op5_d        = op5_q;
        aluop_d      = aluop_q;
        funct3_d     = funct3_q;
        funct7_5_d   = funct7_5_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        req_ready    = 2'b00;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready  = grant_idx ? 2'b10 : 2'b01;
                    op5_d      = grant_idx ? req_op5[1] : req_op5[0];
                    aluop_d    = grant_idx ? req_aluop[3:2] : req_aluop[1:0];
                    funct3_d   = grant_idx ? req_funct3[5:3] : req_funct3[2:0];
                    funct7_5_d = grant_idx ? req_funct7_5[1] : req_funct7_5[0];
                    a_d        = grant_idx ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
                    b_d        = grant_idx ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
                    rsp_id_d   = grant_idx;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                    last_d     = grant_idx;
`endif
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op5_q        <= 1'b0;
            aluop_q      <= 2'b00;
            funct3_q     <= 3'b000;
            funct7_5_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op5_q        <= op5_d;
            aluop_q      <= aluop_d;
            funct3_q     <= funct3_d;
            funct7_5_q   <= funct7_5_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_op5      = op5_q;
    assign alu_aluop    = aluop_q;
    assign alu_funct3   = funct3_q;
    assign alu_funct7_5 = funct7_5_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_op5;
    logic [3:0]        req_aluop;
    logic [5:0]        req_funct3;
    logic [1:0]        req_funct7_5;
    logic [2*XLEN-1:0] req_a;
    logic [2*XLEN-1:0] req_b;
    logic              alu_op5;
    logic [1:0]        alu_aluop;
    logic [2:0]        alu_funct3;
    logic              alu_funct7_5;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [XLEN-1:0]   rsp_result;
    logic              rsp_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op5      (req_op5),
        .req_aluop    (req_aluop),
        .req_funct3   (req_funct3),
        .req_funct7_5 (req_funct7_5),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_op5      (alu_op5),
        .alu_aluop    (alu_aluop),
        .alu_funct3   (alu_funct3),
        .alu_funct7_5 (alu_funct7_5),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero)
    );

    // Shared ALU stand-in: add/sub/and/or/xor chosen by the registered decode fields.
    always_comb begin
        alu_result = alu_a + alu_b;
        if (alu_aluop == ALUOP_BRANCH) begin
            alu_result = alu_a - alu_b;
        end else if (alu_aluop == ALUOP_RTYPE) begin
            case (alu_funct3)
                3'b000:  alu_result = (alu_op5 && alu_funct7_5) ? alu_a - alu_b : alu_a + alu_b;
                3'b111:  alu_result = alu_a & alu_b;
                3'b110:  alu_result = alu_a | alu_b;
                3'b100:  alu_result = alu_a ^ alu_b;
                default: alu_result = alu_a + alu_b;
            endcase
        end
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [1:0]  rv;
        logic        op5;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic        id;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_slot(input int s, input logic op5, input logic [1:0] aluop,
                             input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b);
        req_op5[s]          = op5;
        req_aluop[s*2 +: 2] = aluop;
        req_funct3[s*3 +: 3] = f3;
        req_funct7_5[s]     = f7;
        req_a[s*32 +: 32]   = a;
        req_b[s*32 +: 32]   = b;
    endtask

    function automatic logic exp_tie_id(input int k);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        return 1'b0;
`else
        return k[0];
`endif
    endfunction

    // One table transaction: accept in N, alu_* visible in N+1, response in N+2.
    task automatic run_vec(input int k, input vec_t v);
        int s;
        s = v.rv[1] ? 1 : 0;
        @(negedge clk);
        load_slot(s, v.op5, v.aluop, v.f3, v.f7, v.a, v.b);
        load_slot(1 - s, ~v.op5, ~v.aluop, ~v.f3, ~v.f7, ~v.a, ~v.b);
        req_valid = v.rv;
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(v.rv));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk($sformatf("vec%0d alu_a", k), alu_a, v.a);
        chk($sformatf("vec%0d alu_b", k), alu_b, v.b);
        chk($sformatf("vec%0d rsp_valid_exec", k), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("vec%0d rsp_id", k), 32'(rsp_id), 32'(v.id));
        chk($sformatf("vec%0d rsp_result", k), rsp_result, v.res);
        chk($sformatf("vec%0d rsp_zero", k), 32'(rsp_zero), 32'(v.zero));
        @(posedge clk);
    endtask

    initial begin
        logic        g_id[4];
        int          g_cyc[4];
        int          ng;
        logic        bad_rsp;
        logic        saw;
        logic [31:0] held_res;

        vecs[0] = '{2'b01, 1'b1, 2'b10, 3'b000, 1'b0, 32'd5,      32'd3,      1'b0, 32'd8,      1'b0};
        vecs[1] = '{2'b10, 1'b1, 2'b10, 3'b000, 1'b1, 32'd7,      32'd7,      1'b1, 32'd0,      1'b1};
        vecs[2] = '{2'b01, 1'b0, 2'b00, 3'b010, 1'b0, 32'h100,    32'h20,     1'b0, 32'h120,    1'b0};
        vecs[3] = '{2'b10, 1'b1, 2'b10, 3'b111, 1'b0, 32'hF0F0,   32'h0FF0,   1'b1, 32'h00F0,   1'b0};
        vecs[4] = '{2'b01, 1'b1, 2'b01, 3'b000, 1'b0, 32'd9,      32'd9,      1'b0, 32'd0,      1'b1};
        vecs[5] = '{2'b10, 1'b0, 2'b10, 3'b110, 1'b0, 32'hA0,     32'h0B,     1'b1, 32'hAB,     1'b0};
        vecs[6] = '{2'b01, 1'b0, 2'b10, 3'b000, 1'b1, 32'd10,     32'd3,      1'b0, 32'd13,     1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req_op5 = '0; req_aluop = '0; req_funct3 = '0; req_funct7_5 = '0;
        req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_aluop", 32'(alu_aluop), 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_vec(k, vecs[k]);
        end

        // Reset while the operation sits in EXEC must discard it.
        @(negedge clk);
        load_slot(0, 1'b0, 2'b00, 3'b000, 1'b0, 32'd40, 32'd2);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        chk("midrst accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst alu_a", alu_a, 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        chk("midrst rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("midrst no stale rsp", 32'(saw), 32'd0);

        // Contention: both held valid, responses consumed immediately.
        load_slot(0, 1'b0, 2'b00, 3'b000, 1'b0, 32'd1, 32'd0);
        load_slot(1, 1'b0, 2'b00, 3'b000, 1'b0, 32'd2, 32'd0);
        req_valid = 2'b11;
        ng = 0;
        bad_rsp = 1'b0;
        for (int cyc = 0; cyc < 13; cyc++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin
                g_id[ng]  = req_ready[1];
                g_cyc[ng] = cyc;
                ng++;
            end
            if (rsp_valid && rsp_result != (rsp_id ? 32'd2 : 32'd1)) bad_rsp = 1'b1;
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("contend grant count", 32'(ng), 32'd4);
        chk("contend rsp data", 32'(bad_rsp), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                chk($sformatf("contend id%0d", k), 32'(g_id[k]), 32'(exp_tie_id(k)));
                if (k > 0) chk($sformatf("contend gap%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
            end
        end
        repeat (4) @(negedge clk);

        // Backpressure: response held for 4 cycles, no new grant.
        load_slot(0, 1'b0, 2'b00, 3'b000, 1'b0, 32'h55, 32'h11);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 6 && !saw; n++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("bp rsp seen", 32'(saw), 32'd1);
        held_res = rsp_result;
        chk("bp rsp_result", held_res, 32'h66);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("bp%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_result", n), rsp_result, held_res);
            chk($sformatf("bp%0d alu_a", n), alu_a, 32'h55);
            chk($sformatf("bp%0d req_ready", n), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp handshake req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle req_ready", 32'(req_ready), 32'd1);
        chk("bp idle alu_a held", alu_a, 32'h55);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
